// File: rtl/pipe_reg_elastic_if.sv
// -----------------------------------------------------------------------------
// pipe_reg_elastic_if
//   One valid/ready/data handshake channel between two pipeline stages.
//   The same interface type serves both sides of pipe_reg_elastic.
//
// Signals
//   valid  producer has a beat on data this cycle
//   ready  consumer accepts the beat this cycle
//   data   WIDTH-bit opaque payload (packed stage struct)
//
// Modports
//   master  producer side: drives valid/data, observes ready
//   slave   consumer side: observes valid/data, drives ready
// -----------------------------------------------------------------------------
interface pipe_reg_elastic_if #(
    parameter int WIDTH = 64
) ();

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/pipe_reg_elastic.sv
// -----------------------------------------------------------------------------
// pipe_reg_elastic
//   Elastic pipeline register for inter-stage boundaries (decode->issue,
//   issue->execute). Carries an opaque payload bit-exact and in order, using
//   a valid/ready handshake on both sides. Flush kills every held entry.
//   A saturating counter records the cycles in which the downstream side
//   stalls a valid beat.
//
//   SKID=1: main + skid entry. up_ready comes straight from a flop, which
//           breaks the combinational ready path while keeping 1 beat/cycle.
//   SKID=0: main entry only. up_ready = ~dn_valid | dn_ready (combinational).
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous, active-high reset
//   flush_i      synchronous kill of all held entries
//   up_if        upstream channel (slave): valid/data in, ready out
//   dn_if        downstream channel (master): valid/data out, ready in
//   occupancy_o  entries held: 0..1 (SKID=0), 0..2 (SKID=1)
//   bp_cnt_o     saturating count of cycles with dn_valid=1 & dn_ready=0
// -----------------------------------------------------------------------------
module pipe_reg_elastic #(
    parameter int               WIDTH   = 64,
    parameter int               SKID    = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    pipe_reg_elastic_if.slave  up_if,
    pipe_reg_elastic_if.master dn_if,
    output logic [1:0]         occupancy_o,
    output logic [CNT_W-1:0]   bp_cnt_o
);

    // Main entry (drives the downstream side) and skid entry (SKID=1 only).
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q,  m_data_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] s_data_q,  s_data_d;
    logic             up_ready_q, up_ready_d;
    logic [CNT_W-1:0] bp_cnt_q,  bp_cnt_d;

    logic up_fire;
    logic dn_fire;

    assign up_if.ready = (SKID != 0) ? up_ready_q : (~m_valid_q | dn_if.ready);
    assign up_fire     = up_if.valid & up_if.ready;
    assign dn_fire     = m_valid_q & dn_if.ready;

    assign dn_if.valid = m_valid_q;
    assign dn_if.data  = m_data_q;
    assign occupancy_o = 2'(m_valid_q) + 2'(s_valid_q);
    assign bp_cnt_o    = bp_cnt_q;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through this block can leave one unassigned and infer a latch.
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        s_valid_d  = s_valid_q;
        s_data_d   = s_data_q;
        bp_cnt_d   = bp_cnt_q;

        // Downstream took the main beat: the skid beat (if any) moves up.
        if (dn_fire) begin
            m_valid_d = s_valid_q;
            m_data_d  = s_valid_q ? s_data_q : m_data_q;
            s_valid_d = 1'b0;
            s_data_d  = RST_VAL;
        end

        // Accepting is only possible while the skid entry is empty, so a new
        // beat either lands in main (main free or draining this cycle) or is
        // parked in skid behind a stalled main beat.
        if (up_fire) begin
            if (!m_valid_q || dn_fire) begin
                m_valid_d = 1'b1;
                m_data_d  = up_if.data;
            end else if (SKID != 0) begin
                s_valid_d = 1'b1;
                s_data_d  = up_if.data;
            end
        end

        // Flush overrides the handshake; a coincident dn transfer has already
        // been consumed downstream and a coincident up beat is dropped here.
        if (flush_i) begin
            m_valid_d = 1'b0;
            m_data_d  = RST_VAL;
            s_valid_d = 1'b0;
            s_data_d  = RST_VAL;
        end

        // Stall counting is independent of flush.
        if (m_valid_q && !dn_if.ready && (bp_cnt_q != '1)) begin
            bp_cnt_d = bp_cnt_q + CNT_W'(1);
        end

        up_ready_d = ~s_valid_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: payload registers are reset too, so dn_data is a defined NOP
        // encoding right after reset instead of X.
        if (rst) begin
            m_valid_q  <= 1'b0;
            m_data_q   <= RST_VAL;
            s_valid_q  <= 1'b0;
            s_data_q   <= RST_VAL;
            up_ready_q <= 1'b1;
            bp_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            s_valid_q  <= s_valid_d;
            s_data_q   <= s_data_d;
            up_ready_q <= up_ready_d;
            bp_cnt_q   <= bp_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg_elastic
//   Self-checking bench for pipe_reg_elastic. Two instances share clk/rst:
//   u_sk (SKID=1, CNT_W=3) and u_ns (SKID=0, CNT_W=16), both WIDTH=16.
//   Directed vectors with hand-computed expectations, then a randomized
//   handshake phase scored against per-instance queues.
// -----------------------------------------------------------------------------
module tb_pipe_reg_elastic;

    logic clk = 1'b0;
    logic rst;
    logic sk_flush, ns_flush;
    logic [1:0]  sk_occ, ns_occ;
    logic [2:0]  sk_bp;
    logic [15:0] ns_bp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_reg_elastic_if #(.WIDTH(16)) sk_up ();
    pipe_reg_elastic_if #(.WIDTH(16)) sk_dn ();
    pipe_reg_elastic_if #(.WIDTH(16)) ns_up ();
    pipe_reg_elastic_if #(.WIDTH(16)) ns_dn ();

    pipe_reg_elastic #(.WIDTH(16), .SKID(1), .RST_VAL(16'h0000), .CNT_W(3)) u_sk (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (sk_flush),
        .up_if       (sk_up),
        .dn_if       (sk_dn),
        .occupancy_o (sk_occ),
        .bp_cnt_o    (sk_bp)
    );

    pipe_reg_elastic #(.WIDTH(16), .SKID(0), .RST_VAL(16'h0000), .CNT_W(16)) u_ns (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (ns_flush),
        .up_if       (ns_up),
        .dn_if       (ns_dn),
        .occupancy_o (ns_occ),
        .bp_cnt_o    (ns_bp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sk_drive(input logic uv, input logic [15:0] ud, input logic dr, input logic fl);
        sk_up.valid = uv;
        sk_up.data  = ud;
        sk_dn.ready = dr;
        sk_flush    = fl;
        #1;
    endtask

    task automatic ns_drive(input logic uv, input logic [15:0] ud, input logic dr, input logic fl);
        ns_up.valid = uv;
        ns_up.data  = ud;
        ns_dn.ready = dr;
        ns_flush    = fl;
        #1;
    endtask

    logic [15:0] q_sk[$];
    logic [15:0] q_ns[$];
    logic        sk_stall_prev;
    logic [15:0] sk_prev_data;
    logic        exp_rdy;
    logic [15:0] exp_d;

    initial begin
        rst = 1'b1;
        sk_drive(1'b0, 16'h0, 1'b0, 1'b0);
        ns_drive(1'b0, 16'h0, 1'b0, 1'b0);

        // ---------------- reset ----------------
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("rst_sk_dn_valid", sk_dn.valid, 0);
        check("rst_sk_dn_data",  sk_dn.data,  0);
        check("rst_sk_up_ready", sk_up.ready, 1);
        check("rst_sk_occ",      sk_occ,      0);
        check("rst_sk_bp",       sk_bp,       0);
        check("rst_ns_dn_valid", ns_dn.valid, 0);
        check("rst_ns_dn_data",  ns_dn.data,  0);
        check("rst_ns_up_ready", ns_up.ready, 1);
        check("rst_ns_occ",      ns_occ,      0);
        check("rst_ns_bp",       ns_bp,       0);

        // ---------------- SKID=1 streaming 0x01..0x08 ----------------
        // Beat i is accepted before edge i and is visible on dn before edge i+1.
        for (int i = 0; i < 10; i++) begin
            sk_drive(i < 8, 16'(i + 1), 1'b1, 1'b0);
            check("stream_up_ready", sk_up.ready, 1);
            check("stream_dn_valid", sk_dn.valid, (i >= 1 && i <= 8) ? 1 : 0);
            if (i >= 1 && i <= 8) check("stream_dn_data", sk_dn.data, i);
            step();
        end
        check("stream_occ_end", sk_occ, 0);
        check("stream_bp_end",  sk_bp,  0);

        // ---------------- SKID=1 backpressure fill + drain ----------------
        sk_drive(1'b1, 16'h000A, 1'b0, 1'b0);
        check("bp_a_up_ready", sk_up.ready, 1);
        step();
        sk_drive(1'b1, 16'h000B, 1'b0, 1'b0);
        check("bp_b_up_ready", sk_up.ready, 1);
        check("bp_b_dn_data",  sk_dn.data,  16'h000A);
        step();
        sk_drive(1'b0, 16'h0000, 1'b0, 1'b0);
        check("bp_full_occ",      sk_occ,      2);
        check("bp_full_up_ready", sk_up.ready, 0);
        check("bp_full_bp1",      sk_bp,       1);
        step();
        check("bp_hold_occ",      sk_occ,      2);
        check("bp_hold_up_ready", sk_up.ready, 0);
        check("bp_hold_dn_data",  sk_dn.data,  16'h000A);
        check("bp_hold_bp2",      sk_bp,       2);
        sk_drive(1'b0, 16'h0000, 1'b1, 1'b0);
        check("drain_a_valid", sk_dn.valid, 1);
        check("drain_a_data",  sk_dn.data,  16'h000A);
        step();
        check("drain_b_occ",      sk_occ,      1);
        check("drain_b_data",     sk_dn.data,  16'h000B);
        check("drain_b_up_ready", sk_up.ready, 1);
        step();
        check("drain_done_occ",   sk_occ,      0);
        check("drain_done_valid", sk_dn.valid, 0);
        check("drain_done_bp",    sk_bp,       2);

        // ---------------- SKID=1 flush while full, dn transfer coincident ----
        sk_drive(1'b1, 16'h0011, 1'b0, 1'b0);
        step();
        sk_drive(1'b1, 16'h0022, 1'b0, 1'b0);
        step();                                    // stalled beat: bp 2 -> 3
        sk_drive(1'b1, 16'h000C, 1'b1, 1'b1);
        check("flush_full_occ",      sk_occ,      2);
        check("flush_full_up_ready", sk_up.ready, 0);
        check("flush_dn_beat",       sk_dn.data,  16'h0011);
        step();
        sk_drive(1'b0, 16'h0000, 1'b1, 1'b0);
        check("flush_dn_valid", sk_dn.valid, 0);
        check("flush_occ",      sk_occ,      0);
        check("flush_dn_data",  sk_dn.data,  0);
        check("flush_up_ready", sk_up.ready, 1);
        check("flush_bp_kept",  sk_bp,       3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_no_ghost", sk_dn.valid, 0);
        end

        // Flush coincident with an accepted up beat: the beat is discarded.
        sk_drive(1'b1, 16'h000C, 1'b1, 1'b1);
        check("flush_up_ready_open", sk_up.ready, 1);
        step();
        sk_drive(1'b0, 16'h0000, 1'b1, 1'b0);
        check("flush_up_dropped_v", sk_dn.valid, 0);
        check("flush_up_dropped_o", sk_occ,      0);

        // Flush while stalled: the stall cycle still counts.
        sk_drive(1'b1, 16'h0033, 1'b0, 1'b0);
        step();
        sk_drive(1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        sk_drive(1'b0, 16'h0000, 1'b0, 1'b0);
        check("flush_stall_bp",    sk_bp,       4);
        check("flush_stall_valid", sk_dn.valid, 0);
        check("flush_stall_data",  sk_dn.data,  0);

        // ---------------- bp_cnt saturation (CNT_W=3) ----------------
        sk_drive(1'b1, 16'h0044, 1'b0, 1'b0);
        step();
        sk_drive(1'b0, 16'h0000, 1'b0, 1'b0);
        step();
        step();
        check("sat_bp_mid", sk_bp, 6);
        repeat (8) step();
        check("sat_bp_max",  sk_bp,       7);
        check("sat_hold_v",  sk_dn.valid, 1);
        check("sat_hold_d",  sk_dn.data,  16'h0044);
        sk_drive(1'b0, 16'h0000, 1'b1, 1'b0);
        step();
        check("sat_drained", sk_occ, 0);
        check("sat_bp_kept", sk_bp,  7);

        // ---------------- SKID=0 directed ----------------
        ns_drive(1'b1, 16'h0055, 1'b0, 1'b0);
        check("ns_empty_ready", ns_up.ready, 1);
        step();
        ns_drive(1'b0, 16'h0000, 1'b0, 1'b0);
        check("ns_full_valid", ns_dn.valid, 1);
        check("ns_full_data",  ns_dn.data,  16'h0055);
        check("ns_full_ready", ns_up.ready, 0);
        check("ns_full_occ",   ns_occ,      1);
        ns_drive(1'b0, 16'h0000, 1'b1, 1'b0);
        check("ns_comb_ready", ns_up.ready, 1);
        step();
        check("ns_drain_v", ns_dn.valid, 0);
        check("ns_drain_o", ns_occ,      0);
        ns_drive(1'b1, 16'h0077, 1'b1, 1'b1);
        step();
        ns_drive(1'b0, 16'h0000, 1'b0, 1'b0);
        check("ns_flush_v", ns_dn.valid, 0);
        check("ns_flush_d", ns_dn.data,  0);

        // ---------------- randomized handshake vs scoreboard ----------------
        sk_stall_prev = 1'b0;
        sk_prev_data  = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rst = (cyc == 5000);
            sk_drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
            ns_drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            if (!rst) begin
                exp_rdy = ~ns_dn.valid | ns_dn.ready;
                check("rnd_ns_up_ready", ns_up.ready, exp_rdy);
                exp_rdy = (sk_occ != 2'd2);
                check("rnd_sk_up_ready", sk_up.ready, exp_rdy);
                if (sk_stall_prev) begin
                    check("rnd_sk_hold_v", sk_dn.valid, 1);
                    check("rnd_sk_hold_d", sk_dn.data,  sk_prev_data);
                end
                if (ns_dn.valid && ns_dn.ready) begin
                    check("rnd_ns_nonempty", q_ns.size() != 0, 1);
                    if (q_ns.size() != 0) begin
                        exp_d = q_ns.pop_front();
                        check("rnd_ns_data", ns_dn.data, exp_d);
                    end
                end
                if (sk_dn.valid && sk_dn.ready) begin
                    check("rnd_sk_nonempty", q_sk.size() != 0, 1);
                    if (q_sk.size() != 0) begin
                        exp_d = q_sk.pop_front();
                        check("rnd_sk_data", sk_dn.data, exp_d);
                    end
                end
                if (ns_up.valid && ns_up.ready) q_ns.push_back(ns_up.data);
                if (sk_up.valid && sk_up.ready) q_sk.push_back(sk_up.data);
            end
            sk_stall_prev = !rst && sk_dn.valid && !sk_dn.ready;
            sk_prev_data  = sk_dn.data;
            step();
            if (rst) begin
                q_ns.delete();
                q_sk.delete();
                check("midrst_ns_valid", ns_dn.valid, 0);
                check("midrst_ns_occ",   ns_occ,      0);
                check("midrst_sk_valid", sk_dn.valid, 0);
                check("midrst_sk_occ",   sk_occ,      0);
                check("midrst_sk_bp",    sk_bp,       0);
                check("midrst_sk_ready", sk_up.ready, 1);
            end
        end
        rst = 1'b0;

        // Drain whatever is still held; every scoreboard entry must come out.
        for (int i = 0; i < 4; i++) begin
            sk_drive(1'b0, 16'h0000, 1'b1, 1'b0);
            ns_drive(1'b0, 16'h0000, 1'b1, 1'b0);
            if (ns_dn.valid) begin
                check("drn_ns_nonempty", q_ns.size() != 0, 1);
                if (q_ns.size() != 0) begin
                    exp_d = q_ns.pop_front();
                    check("drn_ns_data", ns_dn.data, exp_d);
                end
            end
            if (sk_dn.valid) begin
                check("drn_sk_nonempty", q_sk.size() != 0, 1);
                if (q_sk.size() != 0) begin
                    exp_d = q_sk.pop_front();
                    check("drn_sk_data", sk_dn.data, exp_d);
                end
            end
            step();
        end
        check("no_loss_ns", q_ns.size(), 0);
        check("no_loss_sk", q_sk.size(), 0);
        check("end_ns_occ", ns_occ, 0);
        check("end_sk_occ", sk_occ, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
